// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver that samples each bit at mid-bit with a
// fixed clocks-per-bit count, packs NUM_WORDS bytes (first byte in the LSBs)
// into one word, and offers it on a valid/ready master port. A completed
// group that cannot be accepted is dropped and flagged with an overrun pulse.
//
// Handshake: m_data is offered while m_valid is high and is held stable until
// the cycle in which m_valid && m_ready (the transfer). m_valid drops after the
// transfer unless a new group is loaded in that same cycle.
module uart_rx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [W_OUT-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int HALF      = CLOCKS_PER_PULSE / 2;
    localparam int CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int BW        = $clog2(BITS_PER_WORD) + 1;
    localparam int WW        = $clog2(NUM_WORDS) + 1;

    localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic                     rx_m;
    logic                     rx_s;
    logic [2:0]               state;
    logic [CW-1:0]            c_clocks;
    logic [BW-1:0]            c_bits;
    logic [WW-1:0]            c_words;
    logic [BITS_PER_WORD-1:0] sh;
    logic [BITS_PER_WORD-1:0] word_buf [NUM_WORDS];
    logic [W_OUT-1:0]         group;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Group being completed: stored bytes below, the byte just received on top.
    always_comb begin
        group = '0;
        for (int i = 0; i < NUM_WORDS - 1; i++) begin
            group[i*BITS_PER_WORD +: BITS_PER_WORD] = word_buf[i];
        end
        group[(NUM_WORDS-1)*BITS_PER_WORD +: BITS_PER_WORD] = sh;
    end

    // Frame FSM, byte packing and output register with drop-on-busy delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            c_clocks  <= '0;
            c_bits    <= '0;
            c_words   <= '0;
            sh        <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                word_buf[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        c_clocks <= '0;
                    end
                end
                START: begin
                    if (c_clocks == HALF_M1) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state    <= DATA;
                            c_clocks <= '0;
                            c_bits   <= '0;
                        end
                    end else begin
                        c_clocks <= c_clocks + CW'(1);
                    end
                end
                DATA: begin
                    if (c_clocks == LAST_CLK) begin
                        sh       <= {rx_s, sh[BITS_PER_WORD-1:1]};
                        c_bits   <= c_bits + BW'(1);
                        c_clocks <= '0;
                        if (c_bits == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        c_clocks <= c_clocks + CW'(1);
                    end
                end
                STOP: begin
                    if (c_clocks == LAST_CLK) begin
                        c_clocks <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            for (int i = 0; i < NUM_WORDS; i++) begin
                                if (c_words == WW'(i)) begin
                                    word_buf[i] <= sh;
                                end
                            end
                            if (c_words == LAST_WORD) begin
                                c_words <= '0;
                                if (!m_valid || m_ready) begin
                                    m_data  <= group;
                                    m_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                c_words <= c_words + WW'(1);
                            end
                        end else begin
                            frame_err <= 1'b1;
                            sh        <= '0;
                            c_words   <= '0;
                            state     <= BREAK;
                        end
                    end else begin
                        c_clocks <= c_clocks + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly upstream of the design's packed-word datapath and is the counterpart of the word-packing UART transmitter. It deserialises 8N1-style UART frames arriving on `rx`, assembles `NUM_WORDS` consecutive bytes into one `W_OUT`-bit word, and presents that word on a valid/ready master interface. Frames are sampled at mid-bit using a fixed clocks-per-bit count, and every word is delivered or explicitly flagged as lost.

## Interface
- `CLOCKS_PER_PULSE`, 4: clock cycles per UART bit. Must be even and ≥ 2.
- `BITS_PER_WORD`, 8: data bits per frame, sent LSB first.
- `W_OUT`, 24: output word width. Must be a multiple of `BITS_PER_WORD`.
- `NUM_WORDS` (localparam) = `W_OUT/BITS_PER_WORD`: frames per output word.
- `HALF` (localparam) = `CLOCKS_PER_PULSE/2`.

- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line. Idle level is 1.
- `m_data` output `NUM_WORDS*BITS_PER_WORD`: assembled word. The first received byte goes in bits [7:0].
- `m_valid` output 1: `m_data` is valid.
- `m_ready` input 1: downstream accepts the word.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun` output 1: one-cycle pulse when a completed word is dropped.

## Operation
- **Input synchroniser**
  - `rx` passes through a two-flop synchroniser to give `rx_s`.
  - Both flops reset to 1.
  - All decisions use `rx_s` only.
- **Counters**
  - `c_clocks` has width `$clog2(CLOCKS_PER_PULSE)`.
  - `c_bits` has width `$clog2(BITS_PER_WORD)+1`.
  - `c_words` has width `$clog2(NUM_WORDS)+1`.
- **Buffers**
  - Shift register `sh`: bits arrive LSB first, are shifted right and inserted at the MSB.
  - Word buffer `buf[NUM_WORDS]`.
- **States**
  - IDLE: when `rx_s==0`, go to START with `c_clocks=0`.
  - START: increment `c_clocks`. At `c_clocks==HALF-1`, sample `rx_s`:
    - 1 means a false start: go to IDLE.
    - 0 means a valid start bit: go to DATA with `c_clocks=0`, `c_bits=0`.
  - DATA: at `c_clocks==CLOCKS_PER_PULSE-1`:
    - shift `rx_s` into `sh`, increment `c_bits`, clear `c_clocks`;
    - after `BITS_PER_WORD` samples, go to STOP.
  - STOP: at `c_clocks==CLOCKS_PER_PULSE-1`, sample `rx_s`:
    - 1: write `buf[c_words]<=sh` and go to IDLE.
      - If `c_words==NUM_WORDS-1`, the group is complete: set `c_words=0` and deliver the group.
      - Otherwise increment `c_words`.
    - 0: pulse `frame_err`, discard `sh` and the partial group (`c_words=0`), go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE.
- **Delivery of a completed group**
  - If `!m_valid` or `m_ready` in that cycle: load `m_data` with {byte N-1,…,byte 0} (the current `sh` as the top byte) and set `m_valid=1`.
  - Otherwise: keep the old `m_data`/`m_valid`, drop the new group and pulse `overrun`.
- **Output handshake**
  - The transfer happens when `m_valid && m_ready`.
  - `m_valid` clears the cycle after the transfer, unless a new group is loaded in that same cycle; in that case `m_valid` stays 1 with the new data.
  - `m_data` is stable while `m_valid && !m_ready`.
- **Extra stop bits**: additional stop/idle bits (e.g. the transmitter's 4 stop bits) are absorbed in IDLE.

## Timing
- **Reset**
  - State = IDLE; all counters = 0; `sh`, `buf` = 0.
  - `m_data=0`, `m_valid=0`, `frame_err=0`, `overrun=0`.
  - Synchroniser flops = 1.
- **Reset mid-frame**: the partial frame and partial group are discarded. A held `m_valid` word is cleared.
- **Pin to `rx_s` latency**: 2 cycles.
- **Frame timing** (t0 = the IDLE cycle that sees `rx_s==0`):
  - START sample at t0+HALF.
  - Data bit k (k = 0..B-1) sampled at t0+HALF+(k+1)·CPP.
  - Stop bit sampled at t0+HALF+(B+1)·CPP.
  - `m_valid`, `frame_err` and `overrun` assert in the cycle after the stop sample. With defaults: t0+39.
- **Back-to-back frames**: re-detected with no gap beyond one stop bit, because IDLE is entered right after the stop sample.
- **Pulse outputs**: `frame_err` and `overrun` are high for exactly one cycle.

## Test plan
- **Basic word**: defaults; send frames 0x56, 0x34, 0x12 with 1 stop bit each → exactly one `m_valid`, `m_data=0x123456`, no error pulses.
- **Loopback**: connect the transmitter's `tx` to `rx` (shared `clk`; the transmitter keeps its own reset style); push 0xA5C30F, 0x000000, 0xFFFFFF with `m_ready=1` → identical words received in order.
- **Back-pressure and overrun**:
  - Hold `m_ready=0` and send 6 bytes (two words) → the first word stays on `m_data`, one `overrun` pulse occurs at the end of the second word.
  - Then assert `m_ready` → one transfer, after which `m_valid=0`.
- **Framing error**:
  - Send 0x11, then 0x22 with stop=0, then a line-high gap, then 0x33, 0x44, 0x55 → one `frame_err` pulse, and the next word is 0x554433.
  - Holding a break (line low 50 cycles) → a single `frame_err`, and no frame is detected until the line returns high.
- **False start**: a 1-cycle low glitch on `rx` → no state change beyond START, and no output or error.
- **Reset mid-frame**: assert `rst` for 1 cycle during DATA of the second byte, then send 3 clean bytes 0x01, 0x02, 0x03 → `m_data=0x030201`, and the first pre-reset byte is not included.
